// File: rtl/err_dif_seq_if.sv
// rtl/err_dif_seq_if.sv - memory and err_dif bus bundle for the halftoning sequencer
interface err_dif_seq_if #(
  parameter int AW = 6
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_rdata;
  logic          mem_wr;
  logic [7:0]    mem_wdata;
  logic          ed_en;
  logic [2:0]    ed_addr;
  logic [7:0]    ed_d;
  logic [7:0]    ed_q;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, ed_en, ed_addr, ed_d,
    input  mem_rdata, ed_q
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, ed_en, ed_addr, ed_d,
    output mem_rdata, ed_q
  );
endinterface

// File: rtl/err_dif_seq.sv
// rtl/err_dif_seq.sv - raster-scan sequencer feeding err_dif for in-place halftoning
module err_dif_seq #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int AW     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  err_dif_seq_if.master bus
);

  localparam logic [2:0] CODE_CEN   = 3'd0;
  localparam logic [2:0] CODE_RIGHT = 3'd1;
  localparam logic [2:0] CODE_LOWL  = 3'd2;
  localparam logic [2:0] CODE_LOWC  = 3'd3;
  localparam logic [2:0] CODE_LOWR  = 3'd4;

  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] OFF_LL   = AW'(WIDTH - 1);
  localparam logic [AW-1:0] OFF_LC   = AW'(WIDTH);
  localparam logic [AW-1:0] OFF_LR   = AW'(WIDTH + 1);
  localparam logic [AW-1:0] LAST_COL = AW'(WIDTH - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_EVAL,
    S_WB,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_k;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_base;
  logic [7:0]    r_shadow [5];
  logic [7:0]    r_res    [5];

  logic          w_last_col;
  logic          w_last_row;
  logic          w_first_col;
  logic [7:0]    w_valid;
  logic [2:0]    w_km1;
  logic [AW-1:0] w_nb_addr;

  function automatic logic [AW-1:0] nb_off(input logic [2:0] k);
    case (k)
      3'd1:    nb_off = ONE;
      3'd2:    nb_off = OFF_LL;
      3'd3:    nb_off = OFF_LC;
      3'd4:    nb_off = OFF_LR;
      default: nb_off = '0;
    endcase
  endfunction

  function automatic logic [2:0] ed_code(input logic [2:0] k);
    case (k)
      3'd1:    ed_code = CODE_RIGHT;
      3'd2:    ed_code = CODE_LOWL;
      3'd3:    ed_code = CODE_LOWC;
      3'd4:    ed_code = CODE_LOWR;
      default: ed_code = CODE_CEN;
    endcase
  endfunction

  // Neighbour validity by index; bits 5..7 stay 0 so the RD drain cycle issues no read.
  always_comb begin
    w_last_col  = (r_col == LAST_COL);
    w_last_row  = (r_row == LAST_ROW);
    w_first_col = (r_col == '0);
    w_valid     = '0;
    w_valid[0]  = 1'b1;
    w_valid[1]  = !w_last_col;
    w_valid[2]  = !w_last_row && !w_first_col;
    w_valid[3]  = !w_last_row;
    w_valid[4]  = !w_last_row && !w_last_col;
    w_km1       = r_k - 3'd1;
    w_nb_addr   = r_base + r_col + nb_off(r_k);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 8'd0;
    bus.ed_en     = 1'b0;
    bus.ed_addr   = 3'd0;
    bus.ed_d      = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        busy = 1'b1;
        if (r_k < 3'd5) begin
          bus.mem_addr = w_nb_addr;
          bus.mem_rd   = w_valid[r_k];
        end
        if (r_k == 3'd5) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy        = 1'b1;
        bus.ed_en   = 1'b1;
        bus.ed_addr = ed_code(r_k);
        bus.ed_d    = r_shadow[r_k];
        if (r_k == 3'd4) begin
          w_next = S_EVAL;
        end
      end
      S_EVAL: begin
        busy        = 1'b1;
        bus.ed_en   = 1'b1;
        bus.ed_addr = ed_code(r_k);
        bus.ed_d    = r_shadow[r_k];
        if (r_k == 3'd4) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        busy          = 1'b1;
        bus.mem_addr  = w_nb_addr;
        bus.mem_wdata = r_res[r_k];
        bus.mem_wr    = w_valid[r_k];
        if (r_k == 3'd4) begin
          w_next = (w_last_row && w_last_col) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Base tracks row*WIDTH incrementally so no multiplier is needed for addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k    <= 3'd0;
      r_row  <= '0;
      r_col  <= '0;
      r_base <= '0;
      for (int i = 0; i < 5; i++) begin
        r_shadow[i] <= 8'd0;
        r_res[i]    <= 8'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k    <= 3'd0;
            r_row  <= '0;
            r_col  <= '0;
            r_base <= '0;
          end
        end
        S_RD: begin
          if (r_k != 3'd0) begin
            r_shadow[w_km1] <= w_valid[w_km1] ? bus.mem_rdata : 8'd0;
          end
          r_k <= (r_k == 3'd5) ? 3'd0 : r_k + 3'd1;
        end
        S_LOAD: begin
          r_k <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
        end
        S_EVAL: begin
          r_res[r_k] <= bus.ed_q;
          r_k        <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
        end
        S_WB: begin
          if (r_k == 3'd4) begin
            r_k <= 3'd0;
            if (!(w_last_row && w_last_col)) begin
              if (w_last_col) begin
                r_col  <= '0;
                r_row  <= r_row + ONE;
                r_base <= r_base + OFF_LC;
              end else begin
                r_col <= r_col + ONE;
              end
            end
          end else begin
            r_k <= r_k + 3'd1;
          end
        end
        default: begin
          r_k <= 3'd0;
        end
      endcase
    end
  end

endmodule
